// File: rtl/io_bus_pkg.sv
// ============================================================================
// Module : io_bus_pkg
// Brief  : Shared FSM encoding, operation codes and default decode/timeout
//          constants for the IO access controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic [31:0] c_uart_base_dflt      = 32'hFFFF_0000;
    localparam logic [31:0] c_uart_mask_dflt      = 32'hFFFF_FFF0;
    localparam logic [7:0]  c_timeout_cycles_dflt = 8'd255;

endpackage : io_bus_pkg

`default_nettype wire

// File: rtl/io_addr_decode.sv
// ============================================================================
// Module : io_addr_decode
// Brief  : Combinational UART region decode of a 32-bit address.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_addr_decode
    import io_bus_pkg::*;
#(
    parameter logic [31:0] UART_BASE = c_uart_base_dflt,
    parameter logic [31:0] UART_MASK = c_uart_mask_dflt
) (
    input  logic [31:0] addr,
    output logic        is_uart
);

    assign is_uart = ((addr & UART_MASK) == (UART_BASE & UART_MASK));

endmodule : io_addr_decode

`default_nettype wire

// File: rtl/io_access_ctrl.sv
// ============================================================================
// Module : io_access_ctrl
// Brief  : Single-outstanding IO access FSM steering one request to UART or
//          memory. Optional stall timeout enabled by IO_ACCESS_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_access_ctrl
    import io_bus_pkg::*;
#(
    parameter logic [31:0] UART_BASE      = c_uart_base_dflt,
    parameter logic [31:0] UART_MASK      = c_uart_mask_dflt,
    parameter logic [7:0]  TIMEOUT_CYCLES = c_timeout_cycles_dflt
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    input  logic        req_read,
    output logic        req_ready,
    output logic        done,
    output logic        err,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        write,
    output logic        read,
    input  logic        stall
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    op_t         r_op;
    logic        r_sel;
    logic        w_accept;
    logic        w_is_uart;
    logic [31:0] w_dec_addr;
    logic        w_timeout;

    assign w_accept = (r_state == ST_IDLE) && (req_write || req_read);

    // Decoder sees the live request in IDLE; only its value at acceptance is kept.
    assign w_dec_addr = (r_state == ST_IDLE) ? req_addr : r_addr;

    io_addr_decode #(
        .UART_BASE (UART_BASE),
        .UART_MASK (UART_MASK)
    ) u_decode (
        .addr    (w_dec_addr),
        .is_uart (w_is_uart)
    );

`ifdef IO_ACCESS_TIMEOUT_EN
    logic [7:0] r_tcnt;

    assign w_timeout = (r_tcnt == TIMEOUT_CYCLES) && stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= 8'd0;
        end else if (w_accept) begin
            r_tcnt <= 8'd0;
        end else if ((r_state == ST_ACCESS) && stall && !w_timeout) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_op    <= OP_READ;
            r_sel   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_op    <= req_write ? OP_WRITE : OP_READ;   // write wins a tie
            r_sel   <= w_is_uart;
        end else if ((r_state == ST_DONE) || (r_state == ST_ABORT)) begin
            r_sel   <= 1'b0;
        end
    end

    // Stall is checked before timeout so a falling stall on the limit completes.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        done      = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        rd_data   = 32'd0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                write   = (r_op == OP_WRITE);
                read    = (r_op == OP_READ);
                rd_data = r_wdata;
                if (!stall) begin
                    w_next = ST_DONE;
                end else if (w_timeout) begin
                    w_next = ST_ABORT;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ABORT: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef IO_ACCESS_TIMEOUT_EN
    assign err = (r_state == ST_ABORT);
`else
    assign err = 1'b0;
`endif

    assign sel = r_sel;

endmodule : io_access_ctrl

`default_nettype wire

// File: tb/tb_io_access_ctrl.sv
// ============================================================================
// Module : tb_io_access_ctrl
// Brief  : Self-checking bench for io_access_ctrl; timeout checks follow
//          IO_ACCESS_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_access_ctrl;

    localparam logic [31:0] c_base = 32'hFFFF_0000;
    localparam logic [31:0] c_mask = 32'hFFFF_FFF0;
    localparam int          c_tout = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic        req_read;
    logic        req_ready;
    logic        done;
    logic        err;
    logic        sel;
    logic [31:0] rd_data;
    logic        write;
    logic        read;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    io_access_ctrl #(
        .UART_BASE      (c_base),
        .UART_MASK      (c_mask),
        .TIMEOUT_CYCLES (8'(c_tout))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .req_read  (req_read),
        .req_ready (req_ready),
        .done      (done),
        .err       (err),
        .sel       (sel),
        .rd_data   (rd_data),
        .write     (write),
        .read      (read),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, req_ready, 1);
        chk({tag, ".done"},  done,      0);
        chk({tag, ".err"},   err,       0);
        chk({tag, ".sel"},   sel,       0);
        chk({tag, ".wr"},    write,     0);
        chk({tag, ".rd"},    read,      0);
        chk({tag, ".data"},  rd_data,   0);
    endtask

    // Entered and left 1 time unit after a rising edge with the FSM idle.
    // Stall is high for the first 'nstall' ACCESS cycles, low afterwards.
    task automatic txn(input logic [31:0] a, input logic [31:0] d,
                       input bit w, input bit r, input int nstall, input bit hold);
        bit exp_sel;
        bit exp_abort;
        int n_acc;
        exp_sel = ((a & c_mask) == (c_base & c_mask));
`ifdef IO_ACCESS_TIMEOUT_EN
        exp_abort = (nstall > c_tout);
        n_acc     = exp_abort ? c_tout + 1 : nstall + 1;
`else
        exp_abort = 1'b0;
        n_acc     = nstall + 1;
`endif
        chk_idle("idle_pre");
        req_addr = a; req_wdata = d; req_write = w; req_read = r; stall = 1'b0;
        @(posedge clk); #1;
        if (!hold) begin
            req_write = 1'b0; req_read = 1'b0;
        end
        for (int k = 0; k < n_acc; k++) begin
            stall = (k < nstall);
            chk("acc.ready", req_ready, 0);
            chk("acc.sel",   sel,       exp_sel);
            chk("acc.wr",    write,     w);
            chk("acc.rd",    read,      r & ~w);
            chk("acc.data",  rd_data,   d);
            chk("acc.done",  done,      0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        chk("end.done",  done,      1);
        chk("end.err",   err,       exp_abort);
        chk("end.wr",    write,     0);
        chk("end.rd",    read,      0);
        chk("end.data",  rd_data,   0);
        chk("end.ready", req_ready, 0);
        chk("end.sel",   sel,       exp_sel);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; stall = 1'b0;
        req_addr = '0; req_wdata = '0; req_write = 1'b0; req_read = 1'b0;
        #2;
        chk_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle("post_reset");

        // UART write, minimum latency
        txn(32'hFFFF_0004, 32'h0000_0041, 1'b1, 1'b0, 0, 1'b0);
        // memory read stalled three cycles
        txn(32'h0000_1000, 32'h0, 1'b0, 1'b1, 3, 1'b0);
        // write and read together: write only
        txn(32'hFFFF_000C, 32'hDEAD_BEEF, 1'b1, 1'b1, 1, 1'b0);
        // just outside the UART window
        txn(32'hFFFF_0010, 32'h1234_5678, 1'b1, 1'b0, 0, 1'b0);
`ifdef IO_ACCESS_TIMEOUT_EN
        txn(32'h0000_2000, 32'h0, 1'b0, 1'b1, 20, 1'b0);
        txn(32'hFFFF_0000, 32'hA5A5_A5A5, 1'b1, 1'b0, c_tout, 1'b0);
        txn(32'h0000_2004, 32'h0, 1'b0, 1'b1, c_tout + 1, 1'b0);
`else
        txn(32'h0000_2000, 32'h0, 1'b0, 1'b1, 20, 1'b0);
`endif
        // read held through ACCESS/DONE; next accept lands right on return to IDLE
        txn(32'h0000_3000, 32'h0, 1'b0, 1'b1, 0, 1'b1);
        txn(32'h0000_3000, 32'h0, 1'b0, 1'b1, 0, 1'b0);

        // asynchronous reset in the middle of a write access
        req_addr = 32'hFFFF_0008; req_wdata = 32'hCAFE_F00D; req_write = 1'b1;
        @(posedge clk); #1;
        req_write = 1'b0; stall = 1'b1;
        chk("mid.wr",  write,   1);
        chk("mid.sel", sel,     1);
        #2 rst = 1'b1;
        #1;
        stall = 1'b0;
        chk_idle("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        txn(32'h0000_4000, 32'h0, 1'b0, 1'b1, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            if ($urandom_range(1, 0) == 1) a = {28'hFFFF_000, 4'($urandom)};
            txn(a, $urandom, 1'($urandom), 1'b1, int'($urandom_range(7, 0)), 1'b0);
            for (int g = int'($urandom_range(2, 0)); g > 0; g--) begin
                chk_idle("gap");
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_io_access_ctrl

`default_nettype wire

// File: doc/io_access_ctrl.md
IO_ACCESS_CTRL -- requirements
Module: io_access_ctrl

Interface
REQ-001 The parameters SHALL be, one per line: name, default, meaning.
- UART_BASE, 32'hFFFF_0000, base address of the UART region.
- UART_MASK, 32'hFFFF_FFF0, address bits compared against UART_BASE.
- TIMEOUT_CYCLES, 8'd255, stall cycles before an access is aborted.
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- req_addr, in, 32, requester address.
- req_wdata, in, 32, requester write data.
- req_write, in, 1, write request.
- req_read, in, 1, read request.
- req_ready, out, 1, high in IDLE; a request is accepted when req_ready and (req_write or req_read) are both high.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle abort flag, coincident with done.
- sel, out, 1, target select: 1 is UART, 0 is memory.
- rd_data, out, 32, latched write data to the target mux.
- write, out, 1, write strobe to the target mux.
- read, out, 1, read strobe to the target mux.
- stall, in, 1, muxed stall from the selected target.

Function
REQ-003 The FSM SHALL have four states: IDLE, ACCESS, DONE and ABORT.
REQ-004 IDLE SHALL behave as follows.
- req_ready=1.
- On acceptance, latch req_addr, req_wdata and the operation, then go to ACCESS next cycle.
REQ-005 If req_write and req_read are both high at acceptance, the access SHALL be a write and the read SHALL be dropped.
REQ-006 Decode: sel SHALL be 1 iff (req_addr & UART_MASK) == (UART_BASE & UART_MASK), evaluated once at acceptance.
REQ-007 sel SHALL be registered and SHALL stay stable from ACCESS entry until the return to IDLE.
REQ-008 ACCESS SHALL behave as follows.
- Drive write or read (exactly one) continuously.
- rd_data = latched wdata.
- stall is sampled each cycle.
- stall=0 leads to DONE.
REQ-009 DONE SHALL last one cycle with done=1, strobes deasserted, and then go to IDLE.
REQ-010 Requests SHALL NOT be accepted in ACCESS, DONE or ABORT: req_ready=0 in those states.
REQ-011 Minimum latency SHALL be as follows, with the access accepted at cycle N.
- Strobe at cycle N+1.
- done at cycle N+2.
- req_ready high again at cycle N+3.
REQ-012 Outside ACCESS, write, read and rd_data SHALL be 0.
REQ-013 sel SHALL return to 0 in IDLE.

Reset
REQ-014 rst=1 SHALL immediately force the following, regardless of the current state, including mid-ACCESS.
- State to IDLE.
- sel, write, read, done and err to 0.
- rd_data to 0.
- Timeout counter to 0.
- Latched address and data to 0.
REQ-015 req_ready SHALL be 1 during reset and on the first cycle after reset.

Configuration
REQ-016 Macro IO_ACCESS_TIMEOUT_EN SHALL control the timeout feature.
REQ-017 With IO_ACCESS_TIMEOUT_EN defined, the block SHALL behave as follows.
- An 8-bit counter clears on ACCESS entry.
- The counter increments each ACCESS cycle with stall=1.
- When the counter equals TIMEOUT_CYCLES while stall=1, go to ABORT.
- ABORT lasts one cycle: strobes are deasserted, done=1 and err=1, then the FSM goes to IDLE.
REQ-018 If stall falls on the same cycle the count reaches TIMEOUT_CYCLES, completion SHALL win: DONE with err=0.
REQ-019 With IO_ACCESS_TIMEOUT_EN undefined, the block SHALL behave as follows.
- ACCESS waits on stall indefinitely.
- No counter is synthesised.
- ABORT is unreachable.
- err is tied to 0.

Structure
REQ-020 Shared package io_bus_pkg SHALL hold the following.
- The FSM state encoding constants.
- Default UART_BASE, UART_MASK and TIMEOUT_CYCLES.
- Operation codes OP_READ and OP_WRITE.
REQ-021 Address decode SHALL be sub-module io_addr_decode: combinational, with ports addr[31:0] and is_uart, parameterised by UART_BASE and UART_MASK.
REQ-022 The FSM, latches and timeout counter SHALL reside in io_access_ctrl.

Verification
REQ-023 Scenario: UART write.
- Stimulus: req_addr=FFFF_0004, req_wdata=0000_0041, req_write=1 at cycle 0, stall=0.
- Response: sel=1, write=1, rd_data=0000_0041 at cycle 1; done=1 at cycle 2; req_ready=1 at cycle 3.
REQ-024 Scenario: memory read with stall.
- Stimulus: req_addr=0000_1000, req_read=1, stall=1 for cycles 1-3.
- Response: sel=0 and read=1 through cycles 1-4; done=1 at cycle 5; err=0.
REQ-025 Scenario: simultaneous write and read.
- Stimulus: req_write=1 and req_read=1 at acceptance.
- Response: only write asserts; read stays 0 throughout.
REQ-026 Scenario: timeout (IO_ACCESS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4).
- Stimulus: stall held at 1.
- Response: ABORT after 4 stalled cycles; done=1 and err=1 for one cycle; strobes at 0.
- Repeat with stall falling exactly at count 4: the response is DONE with err=0.
REQ-027 Scenario: reset mid-access.
- Stimulus: rst=1 asynchronously during ACCESS with write=1.
- Response: write, sel and rd_data go to 0 without waiting for a clock edge; req_ready=1; a new request is accepted on the first cycle after reset.
REQ-028 Scenario: requests in non-IDLE states.
- Stimulus: req_read=1 held during ACCESS and DONE.
- Response: the request is ignored until IDLE; the second access starts exactly at cycle N+3.
